// File: rtl/cellrv32_npu_instruction_fifo.sv
// NPU instruction FIFO: buffers host-written instructions in order
// and presents the head entry to the control coordinator (FWFT).
package cellrv32_npu_pkg;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  dst;
    logic [15:0] imm;
  } instruction_t;
endpackage

module cellrv32_npu_instruction_fifo
  import cellrv32_npu_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     flush_i,
  input  instruction_t             wr_inst_i,
  input  logic                     wr_en_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [31:0]              issued_cnt_o,
  output instruction_t             inst_o,
  output logic                     inst_en_o,
  input  logic                     busy_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  instruction_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic          r_overflow;
  logic [31:0]   r_issued;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  // Status and handshake decode from the current pointer state
  always_comb begin
    w_empty = (r_rd_ptr == r_wr_ptr);
    w_full  = (r_rd_ptr[AW-1:0] == r_wr_ptr[AW-1:0]) &&
              (r_rd_ptr[AW] != r_wr_ptr[AW]);
    w_push  = wr_en_i && !w_full;
    w_pop   = !w_empty && !busy_i && enable_i;
  end

  // Storage write; contents are never reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && w_push)
      r_mem[r_wr_ptr[AW-1:0]] <= wr_inst_i;
  end

  // Pointers, sticky overflow and retire counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_overflow <= 1'b0;
      r_issued   <= '0;
    end else if (flush_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_issued <= r_issued + 32'd1;
      end
      if (wr_en_i && w_full)
        r_overflow <= 1'b1;
    end
  end

  // Output drive; head read is combinational
  always_comb begin
    full_o       = w_full;
    empty_o      = w_empty;
    overflow_o   = r_overflow;
    level_o      = r_wr_ptr - r_rd_ptr;
    issued_cnt_o = r_issued;
    inst_o       = r_mem[r_rd_ptr[AW-1:0]];
    inst_en_o    = !w_empty;
  end

endmodule

// File: tb/tb_cellrv32_npu_instruction_fifo.sv
// Directed bench for the NPU instruction FIFO.
// Expected values are hand-derived per step.
module tb_cellrv32_npu_instruction_fifo;
  import cellrv32_npu_pkg::*;

  localparam int DEPTH = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b1;
  logic         flush = 1'b0;
  instruction_t wr_inst = '0;
  logic         wr_en = 1'b0;
  logic         full;
  logic         empty;
  logic         ovf;
  logic [5:0]   level;
  logic [31:0]  issued;
  instruction_t inst;
  logic         inst_en;
  logic         busy = 1'b0;

  int n_tot = 0;
  int n_pass = 0;
  int n_fail = 0;

  cellrv32_npu_instruction_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (en),
    .flush_i      (flush),
    .wr_inst_i    (wr_inst),
    .wr_en_i      (wr_en),
    .full_o       (full),
    .empty_o      (empty),
    .overflow_o   (ovf),
    .level_o      (level),
    .issued_cnt_o (issued),
    .inst_o       (inst),
    .inst_en_o    (inst_en),
    .busy_i       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_insten"}, 32'(inst_en), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_issued"}, issued, 32'd0);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset("rst");

    // push A,B,C with free-running consumer
    wr_en = 1'b1;
    wr_inst = instruction_t'(32'h0A0A_0001);
    tick();
    chk("t1_A", 32'(inst), 32'h0A0A_0001);
    chk("t1_en", 32'(inst_en), 32'd1);
    wr_inst = instruction_t'(32'h0B0B_0002);
    tick();
    chk("t1_B", 32'(inst), 32'h0B0B_0002);
    chk("t1_cntA", issued, 32'd1);
    wr_inst = instruction_t'(32'h0C0C_0003);
    tick();
    chk("t1_C", 32'(inst), 32'h0C0C_0003);
    wr_en = 1'b0;
    tick();
    chk("t1_cnt", issued, 32'd3);
    chk("t1_empty", 32'(empty), 32'd1);

    // fill past DEPTH while busy
    busy = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      wr_inst = instruction_t'(32'h0100 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_level", 32'(level), 32'd32);
    chk("t2_ovf", 32'(ovf), 32'd1);
    chk("t2_hold", issued, 32'd3);
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("t2_ord%0d", i), 32'(inst), 32'h0100 + i);
      tick();
    end
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_cnt", issued, 32'd35);

    // steady push+pop across pointer wraps
    busy = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      wr_inst = instruction_t'(32'h0200 + i);
      tick();
    end
    chk("t3_lvl0", 32'(level), 32'd31);
    busy = 1'b0;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      wr_inst = instruction_t'(32'h0200 + DEPTH - 1 + k);
      chk($sformatf("t3_ord%0d", k), 32'(inst), 32'h0200 + k);
      tick();
      chk($sformatf("t3_lvl%0d", k), 32'(level), 32'd31);
    end
    wr_en = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      chk($sformatf("t3_tail%0d", i), 32'(inst), 32'h0200 + 3 * DEPTH + i);
      tick();
    end
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_cnt", issued, 32'd162);
    chk("t3_ovf", 32'(ovf), 32'd1);

    // flush with a concurrent push
    busy = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_inst = instruction_t'(32'h0300 + i);
      tick();
    end
    chk("t4_lvl4", 32'(level), 32'd4);
    flush = 1'b1;
    wr_inst = instruction_t'(32'h0999);
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    chk("t4_level", 32'(level), 32'd0);
    chk("t4_insten", 32'(inst_en), 32'd0);
    chk("t4_ovf", 32'(ovf), 32'd0);
    chk("t4_cnt", issued, 32'd162);
    wr_en = 1'b1;
    wr_inst = instruction_t'(32'h0400);
    tick();
    wr_en = 1'b0;
    chk("t4_en", 32'(inst_en), 32'd1);
    chk("t4_inst", 32'(inst), 32'h0400);
    chk("t4_lvl1", 32'(level), 32'd1);
    busy = 1'b0;
    tick();
    chk("t4_cnt2", issued, 32'd163);
    chk("t4_empty", 32'(empty), 32'd1);

    // enable low freezes retirement
    en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_inst = instruction_t'(32'h0500 + i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    tick();
    chk("t5_lvl", 32'(level), 32'd3);
    chk("t5_cnt", issued, 32'd163);
    chk("t5_en", 32'(inst_en), 32'd1);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_ord%0d", i), 32'(inst), 32'h0500 + i);
      tick();
    end
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_cnt2", issued, 32'd166);

    // reset mid-operation
    busy = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_inst = instruction_t'(32'h0600 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("t6_lvl5", 32'(level), 32'd5);
    busy = 1'b0;
    tick();
    chk("t6_lvl4", 32'(level), 32'd4);
    chk("t6_cnt", issued, 32'd167);
    busy = 1'b1;
    tick();
    busy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy = 1'b1;
    chk_reset("t6");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
